bus_arbiter_rr: RTL and testbench

//  N-client round-robin arbiter for the rq/ack/wr_ni memory bus. Sits between N client masters and one

---
 rtl/bus_arbiter_rr.sv | 151 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter: grants one client at a time onto a single rq/ack/wr_ni slave bus,
// returning ack/dataR to the winner and aborting transfers the slave never acknowledges.
//
// state | meaning
// IDLE  | no transfer; pick the next requester starting after the last served client
// BUSY  | s_rq driven from latched winner fields, waiting for s_ack or timeout
// DONE  | one-cycle c_ack/c_err pulse to the granted client
module bus_arbiter_rr #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT     = 15,
  localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            c_rq,
  input  logic [NUM_CLIENTS-1:0]            c_wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_dataW,
  output logic [NUM_CLIENTS-1:0]            c_ack,
  output logic [NUM_CLIENTS-1:0]            c_err,
  output logic [DATA_WIDTH-1:0]             c_dataR,
  output logic                              s_rq,
  output logic                              s_wr_ni,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_dataW,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_dataR,
  output logic [GW-1:0]                     grant_id,
  output logic                              busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           win;
  logic                    found;
  logic                    timeout_hit;
  logic [NUM_CLIENTS-1:0]  c_ack_d, c_err_d;
  logic [DATA_WIDTH-1:0]   c_dataR_d, s_dataW_d;
  logic [ADDR_WIDTH-1:0]   s_address_d;
  logic                    s_rq_d, s_wr_ni_d, busy_d;
  logic [GW-1:0]           grant_d;

  // Scan starts one past the last served client, so it becomes lowest priority.
  always_comb begin
    int idx;
    idx   = 0;
    win   = ptr_q;
    found = 1'b0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && c_rq[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= GW'(NUM_CLIENTS - 1);
      cnt_q     <= '0;
      c_ack     <= '0;
      c_err     <= '0;
      c_dataR   <= '0;
      s_rq      <= 1'b0;
      s_wr_ni   <= 1'b0;
      s_address <= '0;
      s_dataW   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      c_ack     <= c_ack_d;
      c_err     <= c_err_d;
      c_dataR   <= c_dataR_d;
      s_rq      <= s_rq_d;
      s_wr_ni   <= s_wr_ni_d;
      s_address <= s_address_d;
      s_dataW   <= s_dataW_d;
      grant_id  <= grant_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (s_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    c_ack_d     = '0;
    c_err_d     = '0;
    c_dataR_d   = '0;
    s_rq_d      = s_rq;
    s_wr_ni_d   = s_wr_ni;
    s_address_d = s_address;
    s_dataW_d   = s_dataW;
    grant_d     = grant_id;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          s_rq_d      = 1'b1;
          s_wr_ni_d   = c_wr_ni[win];
          s_address_d = c_address[win*ADDR_WIDTH +: ADDR_WIDTH];
          s_dataW_d   = c_dataW[win*DATA_WIDTH +: DATA_WIDTH];
          grant_d     = win;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        // A slave ack in the final timeout cycle still completes normally.
        if (s_ack) begin
          s_rq_d            = 1'b0;
          c_ack_d[grant_id] = 1'b1;
          c_dataR_d         = s_wr_ni ? '0 : s_dataR;
          ptr_d             = grant_id;
        end else if (timeout_hit) begin
          s_rq_d            = 1'b0;
          c_ack_d[grant_id] = 1'b1;
          c_err_d[grant_id] = 1'b1;
          ptr_d             = grant_id;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: table of single-client transfers against a ram slave with a
// programmable ack delay, plus fairness and reset-abort sequences checked through a scoreboard.
module tb_bus_arbiter_rr;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    c_rq, c_wr_ni;
  logic [N*AW-1:0] c_address;
  logic [N*DW-1:0] c_dataW;
  logic [N-1:0]    c_ack, c_err;
  logic [DW-1:0]   c_dataR;
  logic            s_rq, s_wr_ni;
  logic [AW-1:0]   s_address;
  logic [DW-1:0]   s_dataW;
  logic            s_ack = 1'b0;
  logic [DW-1:0]   s_dataR = '0;
  logic [1:0]      grant_id;
  logic            busy;

  bus_arbiter_rr #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .c_rq(c_rq), .c_wr_ni(c_wr_ni), .c_address(c_address),
    .c_dataW(c_dataW), .c_ack(c_ack), .c_err(c_err), .c_dataR(c_dataR), .s_rq(s_rq),
    .s_wr_ni(s_wr_ni), .s_address(s_address), .s_dataW(s_dataW), .s_ack(s_ack),
    .s_dataR(s_dataR), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // ram slave: acks in the ack_delay-th cycle of s_rq high; 0 means never ack
  int            ack_delay;
  int            rq_cycles;
  logic [DW-1:0] mem [16];

  always @(negedge clk) begin
    s_ack   = 1'b0;
    s_dataR = '0;
    if (!reset) begin
      rq_cycles = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
    end else if (s_rq) begin
      rq_cycles++;
      if (ack_delay != 0 && rq_cycles == ack_delay) begin
        s_ack = 1'b1;
        if (s_wr_ni) mem[s_address] = s_dataW;
        else s_dataR = mem[s_address];
      end
    end else begin
      rq_cycles = 0;
    end
  end

  typedef struct {
    int          client;
    logic        wr;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    int          delay;
    logic        err;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct {
    int         client;
    logic       err;
    logic [7:0] data;
  } exp_t;

  vec_t vecs [8];
  vec_t v;
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hi, exp_hi;
  logic got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance to the next falling edge and compare any completion against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (c_ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(c_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_onehot", 32'(c_ack), 32'd1 << e.client);
        check("ack_grant_id", 32'(grant_id), 32'(e.client));
        check("ack_err", 32'(c_err), e.err ? (32'd1 << e.client) : 32'd0);
        check("ack_dataR", 32'(c_dataR), 32'(e.data));
      end
    end else if (c_err != '0) begin
      check("err_without_ack", 32'(c_err), 32'd0);
    end
  endtask

  task automatic push(input int client);
    sb.push_back(exp_t'{client, 1'b0, 8'h00});
  endtask

  // Clients write repeatedly; each keeps c_rq high until its quota of acks is used up.
  task automatic run_auto(input int r0, input int r1, input int r2, input int r3);
    int rem [N];
    int cyc;
    rem = '{r0, r1, r2, r3};
    for (int i = 0; i < N; i++) begin
      c_wr_ni[i]              = 1'b1;
      c_address[i*AW +: AW]   = AW'(8 + i);
      c_dataW[i*DW +: DW]     = DW'(8'h10 + i);
      c_rq[i]                 = (rem[i] > 0);
    end
    cyc = 0;
    while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && cyc < 300) begin
      tick();
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (c_ack[i] && rem[i] > 0) begin
          rem[i]--;
          c_rq[i] = (rem[i] > 0);
        end
      end
    end
    c_rq = '0;
    check("auto_remaining", 32'(rem[0] + rem[1] + rem[2] + rem[3]), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    //            client wr    addr   wdata  delay err   rdata
    vecs[0] = '{2, 1'b1, 4'h3, 8'hA5, 1,  1'b0, 8'h00};
    vecs[1] = '{2, 1'b0, 4'h3, 8'h00, 1,  1'b0, 8'hA5};
    vecs[2] = '{0, 1'b1, 4'h7, 8'h3C, 3,  1'b0, 8'h00};
    vecs[3] = '{3, 1'b0, 4'h7, 8'h00, 15, 1'b0, 8'h3C};
    vecs[4] = '{1, 1'b0, 4'h3, 8'h00, 0,  1'b1, 8'h00};
    vecs[5] = '{1, 1'b1, 4'hF, 8'h5A, 2,  1'b0, 8'h00};
    vecs[6] = '{0, 1'b0, 4'hF, 8'h00, 16, 1'b1, 8'h00};
    vecs[7] = '{3, 1'b0, 4'hF, 8'h00, 1,  1'b0, 8'h5A};

    reset     = 1'b1;
    c_rq      = '0;
    c_wr_ni   = '0;
    c_address = '0;
    c_dataW   = '0;
    ack_delay = 1;
    #2 reset = 1'b0;
    tick();
    tick();
    check("rst_s_rq", 32'(s_rq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_c_ack", 32'(c_ack), 32'd0);
    check("rst_c_err", 32'(c_err), 32'd0);
    check("rst_c_dataR", 32'(c_dataR), 32'd0);
    reset = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      exp_hi    = (v.delay >= 1 && v.delay <= TO) ? v.delay : TO;
      ack_delay = v.delay;
      sb.push_back(exp_t'{v.client, v.err, v.rdata});
      c_wr_ni[v.client]            = v.wr;
      c_address[v.client*AW +: AW] = v.addr;
      c_dataW[v.client*DW +: DW]   = v.wdata;
      c_rq[v.client]               = 1'b1;
      hi  = 0;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick();
        if (t == 0) begin
          check("grant_s_rq", 32'(s_rq), 32'd1);
          check("grant_busy", 32'(busy), 32'd1);
          check("grant_id", 32'(grant_id), 32'(v.client));
          check("grant_s_wr_ni", 32'(s_wr_ni), 32'(v.wr));
          check("grant_s_address", 32'(s_address), 32'(v.addr));
          check("grant_s_dataW", 32'(s_dataW), 32'(v.wdata));
        end
        if (s_rq) hi++;
        if (c_ack[v.client]) begin
          got            = 1'b1;
          c_rq[v.client] = 1'b0;
        end
      end
      check("ack_seen", 32'(got), 32'd1);
      check("s_rq_high_cycles", 32'(hi), 32'(exp_hi));
      tick();
      check("idle_after_done", {29'd0, busy, s_rq, |c_ack}, 32'd0);
    end

    // all four contend from reset: strict rotation 0,1,2,3 twice
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ack_delay = 1;
    tick();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i);
    run_auto(2, 2, 2, 2);

    // clients 1 and 3 only: alternate, ending on client 1
    push(1); push(3); push(1); push(3); push(1);
    run_auto(0, 3, 0, 2);
    tick();

    // reset between edges during a transfer the slave never answers
    ack_delay = 0;
    c_wr_ni[2]          = 1'b0;
    c_address[2*AW +: AW] = 4'h5;
    c_rq[2]             = 1'b1;
    tick();
    check("t6_grant_id", 32'(grant_id), 32'd2);
    check("t6_busy", 32'(busy), 32'd1);
    tick();
    tick();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_s_rq", 32'(s_rq), 32'd0);
    check("t6_rst_c_ack", 32'(c_ack), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_grant_id", 32'(grant_id), 32'd0);
    c_rq = '0;
    tick();
    reset = 1'b1;
    tick();
    ack_delay = 1;
    for (int i = 0; i < N; i++) push(i);
    run_auto(1, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
